// File: rtl/cafea_pkg.sv
// Shared coffee-machine definitions: status codes, ASCII line terminators
// and the message-transmitter state encoding.
package cafea_pkg;

  localparam logic [3:0] MSG_WELCOME   = 4'd0;
  localparam logic [3:0] MSG_CHOOSE    = 4'd1;
  localparam logic [3:0] MSG_COFEE     = 4'd2;
  localparam logic [3:0] MSG_CIOCO     = 4'd3;
  localparam logic [3:0] MSG_MILK      = 4'd4;
  localparam logic [3:0] MSG_SUGAR     = 4'd5;
  localparam logic [3:0] MSG_COIN      = 4'd6;
  localparam logic [3:0] MSG_FUNDS     = 4'd7;
  localparam logic [3:0] MSG_READY     = 4'd8;
  localparam logic [3:0] MSG_MILK_SEL  = 4'd9;
  localparam logic [3:0] MSG_SUGAR_SEL = 4'd10;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CR,
    LF
  } tx_state_t;

endpackage

// File: rtl/cafea_msg_tx_if.sv
// Valid/ready byte stream from the message transmitter to a UART/LCD sink.
interface cafea_msg_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/cafea_msg_rom.sv
// Text table for the status codes: (code, idx) -> ASCII character, code -> length.
// Unused codes 11..15 fall back to the welcome text.
module cafea_msg_rom
  import cafea_pkg::*;
#(
  parameter int MAX_LEN = 20,
  parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [3:0]       code,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       chr,
  output logic [IDX_W-1:0] len
);

  localparam int TW = 8 * MAX_LEN;

  logic [TW-1:0]    str_bits;
  logic [IDX_W-1:0] shift;

  // Strings sit right-justified, so the first character is the most significant used byte
  always_comb begin
    str_bits = TW'("Welcome");
    len      = IDX_W'(7);
    case (code)
      MSG_CHOOSE:    begin str_bits = TW'("Choose");               len = IDX_W'(6);  end
      MSG_COFEE:     begin str_bits = TW'("COFEE");                len = IDX_W'(5);  end
      MSG_CIOCO:     begin str_bits = TW'("CIOCO");                len = IDX_W'(5);  end
      MSG_MILK:      begin str_bits = TW'("EXTRA MILK?");          len = IDX_W'(11); end
      MSG_SUGAR:     begin str_bits = TW'("EXTRA SUGAR?");         len = IDX_W'(12); end
      MSG_COIN:      begin str_bits = TW'("INSERT COIN");          len = IDX_W'(11); end
      MSG_FUNDS:     begin str_bits = TW'("INSUFICIENT FUNDS");    len = IDX_W'(17); end
      MSG_READY:     begin str_bits = TW'("READY");                len = IDX_W'(5);  end
      MSG_MILK_SEL:  begin str_bits = TW'("EXTRA MILK SELECTED");  len = IDX_W'(19); end
      MSG_SUGAR_SEL: begin str_bits = TW'("EXTRA SUGAR SELECTED"); len = IDX_W'(20); end
      default:       begin end
    endcase
  end

  assign shift = len - idx - IDX_W'(1);
  assign chr   = 8'(str_bits >> {shift, 3'b000});

endmodule

// File: rtl/cafea_msg_tx.sv
// Turns each new coffee-machine status code into its ASCII text line and
// streams it one byte per valid/ready handshake, optionally followed by CR LF.
module cafea_msg_tx
  import cafea_pkg::*;
#(
  parameter int MAX_LEN = 20,
  parameter bit EOL_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            msg,
  cafea_msg_tx_if.master        tx,
  output logic                  busy,
  output logic [7:0]            lines
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       last_code_q, last_code_d;
  logic             last_valid_q, last_valid_d;
  logic [3:0]       pend_code_q, pend_code_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       lines_q, lines_d;
  logic [7:0]       rom_chr;
  logic [IDX_W-1:0] rom_len;
  logic             accept;
  logic             line_done;

  cafea_msg_rom #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_rom (
    .code (last_code_q),
    .idx  (idx_q),
    .chr  (rom_chr),
    .len  (rom_len)
  );

  assign busy        = (state_q != IDLE);
  assign accept      = busy && tx.tx_ready;
  assign tx.tx_valid = busy;
  assign lines       = lines_q;

  always_comb begin
    case (state_q)
      SEND:    tx.tx_data = rom_chr;
      CR:      tx.tx_data = ASCII_CR;
      LF:      tx.tx_data = ASCII_LF;
      default: tx.tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_valid_q <= 1'b0;
      lines_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_code_q  <= last_code_d;
      last_valid_q <= last_valid_d;
      pend_code_q  <= pend_code_d;
      pend_valid_q <= pend_valid_d;
      lines_q      <= lines_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_code_d  = last_code_q;
    last_valid_d = last_valid_q;
    pend_code_d  = pend_code_q;
    pend_valid_d = pend_valid_q;
    lines_d      = lines_q;
    line_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!last_valid_q || (msg != last_code_q)) begin
          state_d      = SEND;
          last_code_d  = msg;
          last_valid_d = 1'b1;
          idx_d        = '0;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_q == rom_len - IDX_W'(1)) begin
            if (EOL_EN) state_d = CR;
            else        line_done = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      CR: begin
        if (accept) state_d = LF;
      end
      LF: begin
        if (accept) line_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Only the newest differing code is remembered; returning to the current code cancels it
    if (busy) begin
      pend_valid_d = (msg != last_code_q);
      pend_code_d  = msg;
    end

    // A pending code starts its line on the same edge, so there is no idle gap between lines
    if (line_done) begin
      lines_d      = lines_q + 8'd1;
      pend_valid_d = 1'b0;
      if (pend_valid_q) begin
        state_d     = SEND;
        last_code_d = pend_code_q;
        idx_d       = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cafea_msg_tx.sv
// Directed bench for cafea_msg_tx: a vector table for the first line after reset,
// then hand-written sequences for stalls, back-to-back lines, cancel, reset and EOL_EN=0.
module tb_cafea_msg_tx;

  typedef struct {
    logic       rst;
    logic [3:0] msg;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic [7:0] exp_lines;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst0;
  logic [3:0] msg;
  logic [3:0] msg0;
  logic       busy1, busy0;
  logic [7:0] lines1, lines0;

  int checks = 0;
  int errors = 0;

  vec_t vecs[13];

  cafea_msg_tx_if tx_if1();
  cafea_msg_tx_if tx_if0();

  cafea_msg_tx #(.MAX_LEN(20), .EOL_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .msg   (msg),
    .tx    (tx_if1.master),
    .busy  (busy1),
    .lines (lines1)
  );

  cafea_msg_tx #(.MAX_LEN(20), .EOL_EN(1'b0)) dut_noeol (
    .clk   (clk),
    .rst   (rst0),
    .msg   (msg0),
    .tx    (tx_if0.master),
    .busy  (busy0),
    .lines (lines0)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] m, logic rd, logic v,
                              logic [7:0] d, logic b, logic [7:0] l);
    vec_t t;
    t.rst = r; t.msg = m; t.ready = rd;
    t.exp_valid = v; t.exp_data = d; t.exp_busy = b; t.exp_lines = l;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    msg             = v.msg;
    tx_if1.tx_ready = v.ready;
    step();
  endtask

  function automatic logic get_valid(input bit sel);
    return sel ? tx_if0.tx_valid : tx_if1.tx_valid;
  endfunction

  function automatic logic [7:0] get_data(input bit sel);
    return sel ? tx_if0.tx_data : tx_if1.tx_data;
  endfunction

  task automatic set_ready(input bit sel, input logic r);
    if (sel) tx_if0.tx_ready = r;
    else     tx_if1.tx_ready = r;
  endtask

  // Collects accepted bytes and compares them with the text (plus CR LF when eol)
  task automatic recv_line(input bit sel, input string name, input string text,
                           input bit eol, input bit toggle, input int skip);
    logic [7:0] got[$];
    logic [7:0] exp_b;
    logic [7:0] prev_data;
    bit         prev_stall;
    logic       rdy;
    int         want;
    int         cyc;
    want       = text.len() + (eol ? 2 : 0) - skip;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    cyc        = 0;
    while (got.size() < want && cyc < 200) begin
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      set_ready(sel, rdy);
      if (prev_stall) begin
        checkOutput({name, " hold valid"}, 32'(get_valid(sel)), 32'd1);
        checkOutput({name, " hold data"}, 32'(get_data(sel)), 32'(prev_data));
      end
      if (get_valid(sel) && rdy) got.push_back(get_data(sel));
      prev_stall = get_valid(sel) && !rdy;
      prev_data  = get_data(sel);
      step();
      cyc++;
    end
    set_ready(sel, 1'b1);
    checkOutput({name, " byte count"}, 32'(got.size()), 32'(want));
    for (int i = 0; i < got.size() && i < want; i++) begin
      int k;
      k = i + skip;
      if (k < text.len())       exp_b = text[k];
      else if (k == text.len()) exp_b = 8'h0D;
      else                      exp_b = 8'h0A;
      checkOutput($sformatf("%s byte %0d", name, k), 32'(got[i]), 32'(exp_b));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    msg             = 4'd0;
    tx_if1.tx_ready = 1'b1;
    rst0            = 1'b1;
    msg0            = 4'd13;
    tx_if0.tx_ready = 1'b1;

    // First line after reset: "Welcome" CR LF, one byte per cycle
    vecs[0]  = mk(1'b1, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    vecs[1]  = mk(1'b1, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    vecs[2]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h57, 1'b1, 8'd0);
    vecs[3]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h65, 1'b1, 8'd0);
    vecs[4]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h6C, 1'b1, 8'd0);
    vecs[5]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h63, 1'b1, 8'd0);
    vecs[6]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h6F, 1'b1, 8'd0);
    vecs[7]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h6D, 1'b1, 8'd0);
    vecs[8]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h65, 1'b1, 8'd0);
    vecs[9]  = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h0D, 1'b1, 8'd0);
    vecs[10] = mk(1'b0, 4'd0, 1'b1, 1'b1, 8'h0A, 1'b1, 8'd0);
    vecs[11] = mk(1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1);
    vecs[12] = mk(1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("t1 v%0d valid", i), 32'(tx_if1.tx_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("t1 v%0d data", i),  32'(tx_if1.tx_data),  32'(vecs[i].exp_data));
      checkOutput($sformatf("t1 v%0d busy", i),  32'(busy1),           32'(vecs[i].exp_busy));
      checkOutput($sformatf("t1 v%0d lines", i), 32'(lines1),          32'(vecs[i].exp_lines));
    end

    // Stalling sink: ready toggles every cycle
    msg = 4'd7;
    recv_line(1'b0, "t2 funds", "INSUFICIENT FUNDS", 1'b1, 1'b1, 0);
    checkOutput("t2 lines", 32'(lines1), 32'd2);
    checkOutput("t2 busy", 32'(busy1), 32'd0);

    // Burst of changes during a line: only the newest code follows, with no idle gap
    msg = 4'd10;
    tx_if1.tx_ready = 1'b0;
    step();
    checkOutput("t3 first valid", 32'(tx_if1.tx_valid), 32'd1);
    checkOutput("t3 first data", 32'(tx_if1.tx_data), 32'h45);
    msg = 4'd4;
    step();
    msg = 4'd5;
    step();
    msg = 4'd8;
    step();
    checkOutput("t3 stalled data", 32'(tx_if1.tx_data), 32'h45);
    recv_line(1'b0, "t3 sugar_sel", "EXTRA SUGAR SELECTED", 1'b1, 1'b0, 0);
    checkOutput("t3 no bubble valid", 32'(tx_if1.tx_valid), 32'd1);
    checkOutput("t3 no bubble data", 32'(tx_if1.tx_data), 32'h52);
    checkOutput("t3 no bubble busy", 32'(busy1), 32'd1);
    checkOutput("t3 mid lines", 32'(lines1), 32'd3);
    recv_line(1'b0, "t3 ready", "READY", 1'b1, 1'b0, 0);
    checkOutput("t3 lines", 32'(lines1), 32'd4);
    checkOutput("t3 busy", 32'(busy1), 32'd0);

    // Change that reverts before the line ends is cancelled
    msg = 4'd2;
    step();
    checkOutput("t4 byte0", 32'(tx_if1.tx_data), 32'h43);
    msg = 4'd3;
    step();
    checkOutput("t4 byte1", 32'(tx_if1.tx_data), 32'h4F);
    msg = 4'd2;
    step();
    checkOutput("t4 byte2", 32'(tx_if1.tx_data), 32'h46);
    recv_line(1'b0, "t4 cofee", "COFEE", 1'b1, 1'b0, 2);
    checkOutput("t4 lines", 32'(lines1), 32'd5);
    checkOutput("t4 busy", 32'(busy1), 32'd0);
    repeat (4) step();
    checkOutput("t4 idle valid", 32'(tx_if1.tx_valid), 32'd0);
    checkOutput("t4 idle lines", 32'(lines1), 32'd5);

    // Reset mid-line abandons it; the current code is resent from the start
    msg = 4'd3;
    step();
    step();
    step();
    checkOutput("t5 byte2", 32'(tx_if1.tx_data), 32'h4F);
    step();
    checkOutput("t5 byte3", 32'(tx_if1.tx_data), 32'h43);
    rst = 1'b1;
    step();
    checkOutput("t5 rst valid", 32'(tx_if1.tx_valid), 32'd0);
    checkOutput("t5 rst data", 32'(tx_if1.tx_data), 32'd0);
    checkOutput("t5 rst busy", 32'(busy1), 32'd0);
    checkOutput("t5 rst lines", 32'(lines1), 32'd0);
    rst = 1'b0;
    recv_line(1'b0, "t5 cioco", "CIOCO", 1'b1, 1'b0, 0);
    checkOutput("t5 lines", 32'(lines1), 32'd1);

    // No line terminator; unused code 13 maps to the welcome text
    rst0 = 1'b0;
    recv_line(1'b1, "t6 code13", "Welcome", 1'b0, 1'b0, 0);
    checkOutput("t6 lines a", 32'(lines0), 32'd1);
    checkOutput("t6 busy a", 32'(busy0), 32'd0);
    msg0 = 4'd0;
    recv_line(1'b1, "t6 code0", "Welcome", 1'b0, 1'b0, 0);
    checkOutput("t6 lines b", 32'(lines0), 32'd2);
    step();
    checkOutput("t6 busy b", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
